// File: rtl/ps2_serial_rx_if.sv
// Received-byte stream from the PS/2 receiver to the keyboard event decoder.
// The master drives the last byte, its one-cycle valid strobe and the frame-error strobe.
interface ps2_serial_rx_if;
  typedef logic [7:0] byte_t;

  byte_t data_o;
  logic  valid_o;
  logic  error_o;

  modport master (output data_o, output valid_o, output error_o);
  modport slave  (input  data_o, input  valid_o, input  error_o);
endinterface

// File: rtl/ps2_serial_rx.sv
// PS/2 device-to-host frame receiver: synchronize, glitch-filter ps2_clk, decode 11-bit frames.
// Optional inter-edge frame timeout is built only when PS2_SERIAL_RX_TIMEOUT_EN is defined.
module ps2_serial_rx #(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  ps2_serial_rx_if.master rx
);
  typedef logic [7:0] byte_t;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

  if (FILTER_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_serial_rx: FILTER_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  logic              clk_p0, clk_p1;
  logic              dat_p0, dat_p1;
  logic              filt_clk, filt_prev;
  logic [FILT_W-1:0] filt_cnt;
  logic              edge_evt;

  state_t            state;
  logic [2:0]        bit_cnt;
  byte_t             shift_q;
  logic              par_q;
  byte_t             data_q;
  logic              valid_q;
  logic              error_q;

  // Stage p0/p1: two-flop synchronizers, idle-high reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_i;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data_i;
      dat_p1 <= dat_p0;
    end
  end

  // Filter: a level change is accepted only after FILTER_CYCLES uninterrupted cycles
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_p1 != filt_clk) begin
        if (filt_cnt == FILT_LAST) begin
          filt_clk <= clk_p1;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FILT_W'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign edge_evt = filt_prev & ~filt_clk;

`ifdef PS2_SERIAL_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Frame FSM: every transition is triggered by a filtered falling edge
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
`ifdef PS2_SERIAL_RX_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (edge_evt) begin
        unique case (state)
          IDLE: begin
            if (!dat_p1) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_q <= {dat_p1, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_q <= dat_p1;
            state <= STOP;
          end
          STOP: begin
            if (dat_p1 && (^{shift_q, par_q})) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PS2_SERIAL_RX_TIMEOUT_EN
      if (edge_evt || state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt  <= '0;
        error_q <= 1'b1;
        state   <= IDLE;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
`endif
    end
  end

  assign rx.data_o  = data_q;
  assign rx.valid_o = valid_q;
  assign rx.error_o = error_q;
endmodule

// File: tb/tb_ps2_serial_rx.sv
// Randomized frame bench for ps2_serial_rx against a frame-level reference model.
// Also covers glitch rejection, reset mid-frame and (with PS2_SERIAL_RX_TIMEOUT_EN) the timeout.
module tb_ps2_serial_rx;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_serial_rx_if rx();

  ps2_serial_rx #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(50000)) dut (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .rx        (rx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  logic [7:0] exp_data = 8'h00;

  always @(negedge clk) begin
    if (rx.valid_o) n_valid++;
    if (rx.error_o) n_err++;
    if (rx.valid_o && rx.error_o) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_clk(2);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of frame {start 0, d LSB-first, par, stp}; glitch_at = bit index
  // whose high phase gets a 2-cycle low glitch, or -1.
  task automatic send_bits(input logic [7:0] d, input logic par, input logic stp,
                           input int nbits, input int glitch_at);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        wait_clk(5);
        glitch();
        wait_clk(HALF - 7);
      end else begin
        wait_clk(HALF);
      end
    end
    ps2_data = 1'b1;
  endtask

  // Reference model: a frame is accepted iff stop is 1 and data plus parity hold an odd count of ones.
  task automatic frame_check(input string tag, input logic [7:0] d, input logic par,
                             input logic stp, input int glitch_at);
    int v0, e0;
    bit good;
    v0 = n_valid;
    e0 = n_err;
    good = stp && ((($countones(d) + int'(par)) % 2) == 1);
    send_bits(d, par, stp, 11, glitch_at);
    wait_clk(30);
    if (good) exp_data = d;
    check({tag, ".valid"}, n_valid - v0, good ? 1 : 0);
    check({tag, ".error"}, n_err - e0, good ? 0 : 1);
    check({tag, ".data"}, rx.data_o, exp_data);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] d;
    logic par, stp;
    int r, g;

    wait_clk(5);
    check("rst.data", rx.data_o, 8'h00);
    check("rst.valid", rx.valid_o, 0);
    check("rst.error", rx.error_o, 0);
    reset_n = 1'b1;
    wait_clk(10);

    frame_check("f1c", 8'h1C, 1'b0, 1'b1, -1);
    frame_check("f0_badpar", 8'hF0, 1'b0, 1'b1, -1);
    frame_check("f0_good", 8'hF0, 1'b1, 1'b1, -1);
    frame_check("f1c_badstop", 8'h1C, 1'b0, 1'b0, -1);

    // Idle glitch with data low: would look like a start bit if not filtered
    ps2_data = 1'b0;
    wait_clk(5);
    glitch();
    wait_clk(20);
    ps2_data = 1'b1;
    wait_clk(20);
    frame_check("glitch_mid", 8'h1C, 1'b0, 1'b1, 4);

    // Reset after the 5th data bit (start + 5 = 6 bits)
    v0 = n_valid;
    e0 = n_err;
    send_bits(8'h1C, 1'b0, 1'b1, 6, -1);
    reset_n = 1'b0;
    #1;
    check("rstmid.data", rx.data_o, 8'h00);
    check("rstmid.valid", rx.valid_o, 0);
    check("rstmid.error", rx.error_o, 0);
    wait_clk(3);
    reset_n = 1'b1;
    exp_data = 8'h00;
    wait_clk(20);
    check("rstmid.no_pulse", (n_valid - v0) + (n_err - e0), 0);
    frame_check("post_rst", 8'h1C, 1'b0, 1'b1, -1);

`ifdef PS2_SERIAL_RX_TIMEOUT_EN
    v0 = n_valid;
    e0 = n_err;
    send_bits(8'h55, 1'b1, 1'b1, 4, -1);
    wait_clk(50000 + 200);
    check("timeout.error", n_err - e0, 1);
    check("timeout.valid", n_valid - v0, 0);
    frame_check("post_to", 8'hE0, 1'b0, 1'b1, -1);
`endif

    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 7));
      par = ~^d;
      stp = 1'b1;
      if (r < 2) par = ~par;
      else if (r == 2) stp = 1'b0;
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      frame_check("rnd", d, par, stp, g);
    end

    check("never_both", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
